// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS-I controller: FSM states, opcode/funct
// fields, ALU operation codes and datapath mux selects.
package mips_pkg;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_REGB  = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// Maps the FSM's aluop plus the R-type funct field onto the 3-bit ALU operation.
module alu_decoder
  import mips_pkg::*;
(
  input  logic [1:0] aluop_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alucontrol_o
);

  always_comb begin
    alucontrol_o = ALU_ADD;
    case (aluop_i)
      ALUOP_ADD: alucontrol_o = ALU_ADD;
      ALUOP_SUB: alucontrol_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct_i)
          FUNCT_ADD: alucontrol_o = ALU_ADD;
          FUNCT_SUB: alucontrol_o = ALU_SUB;
          FUNCT_AND: alucontrol_o = ALU_AND;
          FUNCT_OR:  alucontrol_o = ALU_OR;
          FUNCT_SLT: alucontrol_o = ALU_SLT;
          default:   alucontrol_o = ALU_ADD;
        endcase
      end
      default: alucontrol_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS-I main controller: one state per datapath step, Moore-style outputs.
// Define BNE_SUPPORT_EN to decode bne (opcode 000101) as an inverted-sense branch.
module mc_control_fsm
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       iord,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       irwrite,
  output logic       memwrite,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       pc_en,
  output logic [2:0] alucontrol,
  output logic [3:0] state
);

  state_e     state_q, state_d;
  logic       pcwrite, branch;
  logic       irwrite_raw, memwrite_raw, regwrite_raw;
  logic [1:0] aluop;
  logic       branch_cond;

  // NOTE: sequential state uses non-blocking assignment so every register samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_d;
  end

  // NOTE: every combinational output gets a default before the case so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH: state_d = DECODE;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXEC;
          OP_BEQ:       state_d = BRANCH;
`ifdef BNE_SUPPORT_EN
          OP_BNE:       state_d = BRANCH;
`endif
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JUMP;
          default:      state_d = FETCH;
        endcase
      end
      MEMADR: begin
        if (opcode == OP_SW)      state_d = MEMWR;
        else if (opcode == OP_LW) state_d = MEMRD;
        else                      state_d = FETCH;
      end
      MEMRD:   state_d = MEMWB;
      EXEC:    state_d = ALUWB;
      ADDIEX:  state_d = ADDIWB;
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    iord         = 1'b0;
    alusrca      = 1'b0;
    alusrcb      = SRCB_REGB;
    pcsrc        = PCSRC_ALU;
    irwrite_raw  = 1'b0;
    memwrite_raw = 1'b0;
    regwrite_raw = 1'b0;
    regdst       = 1'b0;
    memtoreg     = 1'b0;
    pcwrite      = 1'b0;
    branch       = 1'b0;
    aluop        = ALUOP_ADD;
    case (state_q)
      FETCH: begin
        irwrite_raw = 1'b1;
        pcwrite     = 1'b1;
        alusrcb     = SRCB_FOUR;
      end
      DECODE: alusrcb = SRCB_IMMSH;
      MEMADR, ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
      end
      MEMRD: iord = 1'b1;
      MEMWB: begin
        regwrite_raw = 1'b1;
        memtoreg     = 1'b1;
      end
      MEMWR: begin
        iord         = 1'b1;
        memwrite_raw = 1'b1;
      end
      EXEC: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
      end
      ALUWB: begin
        regwrite_raw = 1'b1;
        regdst       = 1'b1;
      end
      ADDIWB: regwrite_raw = 1'b1;
      BRANCH: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc   = PCSRC_ALUOUT;
        branch  = 1'b1;
      end
      JUMP: begin
        pcsrc   = PCSRC_JUMP;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef BNE_SUPPORT_EN
  assign branch_cond = zero ^ (opcode == OP_BNE);
`else
  assign branch_cond = zero;
`endif

  // Write enables are gated by rst_n so nothing commits while reset is held,
  // even though the state register already presents FETCH.
  assign irwrite  = irwrite_raw  & rst_n;
  assign memwrite = memwrite_raw & rst_n;
  assign regwrite = regwrite_raw & rst_n;
  assign pc_en    = (pcwrite | (branch & branch_cond)) & rst_n;
  assign state    = state_q;

  alu_decoder u_alu_decoder (
    .aluop_i      (aluop),
    .funct_i      (funct),
    .alucontrol_o (alucontrol)
  );

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: walks each instruction class cycle by cycle
// against hand-derived state sequences and control values.
module tb_mc_control_fsm;
  import mips_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode, funct;
  logic       zero;
  logic       iord, alusrca, irwrite, memwrite, regwrite, regdst, memtoreg, pc_en;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;

  int errors = 0;
  int checks = 0;

  mc_control_fsm dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .iord       (iord),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .irwrite    (irwrite),
    .memwrite   (memwrite),
    .regwrite   (regwrite),
    .regdst     (regdst),
    .memtoreg   (memtoreg),
    .pc_en      (pc_en),
    .alucontrol (alucontrol),
    .state      (state)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; opcode = OP_LW; funct = 6'd0; zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (state !== 4'(FETCH)) begin errors++; $display("FAIL reset_state: got %0d want %0d", state, FETCH); end
    checks++; if (pc_en !== 1'b0) begin errors++; $display("FAIL reset_pc_en: got %b want 0", pc_en); end
    checks++; if (irwrite !== 1'b0) begin errors++; $display("FAIL reset_irwrite: got %b want 0", irwrite); end
    checks++; if (memwrite !== 1'b0 || regwrite !== 1'b0) begin errors++; $display("FAIL reset_writes: got mw=%b rw=%b want 0 0", memwrite, regwrite); end
    checks++; if (alusrcb !== 2'b01 || alusrca !== 1'b0 || iord !== 1'b0) begin errors++; $display("FAIL reset_fetch_sel: got srcb=%b srca=%b iord=%b want 01 0 0", alusrcb, alusrca, iord); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (pc_en !== 1'b1 || irwrite !== 1'b1) begin errors++; $display("FAIL release_fetch: got pc_en=%b irwrite=%b want 1 1", pc_en, irwrite); end
  endtask

  task automatic test_lw();
    state_e exp[6] = '{FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH};
    opcode = OP_LW;
    for (int i = 0; i < 6; i++) begin
      checks++; if (state !== 4'(exp[i])) begin errors++; $display("FAIL lw_state[%0d]: got %0d want %0d", i, state, exp[i]); end
      checks++; if (regwrite !== (i == 4) || memtoreg !== (i == 4)) begin errors++; $display("FAIL lw_wb[%0d]: got rw=%b m2r=%b want %b", i, regwrite, memtoreg, i == 4); end
      checks++; if (iord !== (i == 3)) begin errors++; $display("FAIL lw_iord[%0d]: got %b want %b", i, iord, i == 3); end
      if (i == 1) begin
        checks++; if (alusrcb !== 2'b11) begin errors++; $display("FAIL decode_srcb: got %b want 11", alusrcb); end
      end
      if (i == 3) opcode = 6'b111111;  // late opcode change must not disturb MEMRD->MEMWB
      if (i < 5) step();
    end
  endtask

  task automatic test_rtype();
    logic [5:0] f_tab[6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};
    logic [2:0] a_tab[6] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b010};
    for (int k = 0; k < 6; k++) begin
      opcode = OP_RTYPE; funct = f_tab[k];
      step();
      checks++; if (state !== 4'(DECODE)) begin errors++; $display("FAIL rt_decode[%0d]: got %0d want %0d", k, state, DECODE); end
      step();
      checks++; if (state !== 4'(EXEC) || alusrca !== 1'b1) begin errors++; $display("FAIL rt_exec[%0d]: got st=%0d srca=%b want %0d 1", k, state, alusrca, EXEC); end
      checks++; if (alucontrol !== a_tab[k]) begin errors++; $display("FAIL rt_aluctl[%0d]: got %b want %b", k, alucontrol, a_tab[k]); end
      step();
      checks++; if (state !== 4'(ALUWB) || regwrite !== 1'b1 || regdst !== 1'b1) begin errors++; $display("FAIL rt_aluwb[%0d]: got st=%0d rw=%b rd=%b want %0d 1 1", k, state, regwrite, regdst, ALUWB); end
      step();
      checks++; if (state !== 4'(FETCH)) begin errors++; $display("FAIL rt_cpi[%0d]: got %0d want %0d", k, state, FETCH); end
    end
  endtask

  task automatic test_beq();
    logic z_tab[2] = '{1'b1, 1'b0};
    for (int k = 0; k < 2; k++) begin
      opcode = OP_BEQ; zero = z_tab[k];
      step();
      checks++; if (state !== 4'(DECODE) || pc_en !== 1'b0) begin errors++; $display("FAIL beq_decode[%0d]: got st=%0d pc_en=%b want %0d 0", k, state, pc_en, DECODE); end
      step();
      checks++; if (state !== 4'(BRANCH) || pcsrc !== 2'b01 || alucontrol !== 3'b110) begin errors++; $display("FAIL beq_branch[%0d]: got st=%0d pcsrc=%b aluctl=%b want %0d 01 110", k, state, pcsrc, alucontrol, BRANCH); end
      checks++; if (pc_en !== z_tab[k]) begin errors++; $display("FAIL beq_pc_en[%0d]: got %b want %b", k, pc_en, z_tab[k]); end
      step();
      checks++; if (state !== 4'(FETCH)) begin errors++; $display("FAIL beq_cpi[%0d]: got %0d want %0d", k, state, FETCH); end
    end
    zero = 1'b0;
  endtask

  task automatic test_addi();
    opcode = OP_ADDI;
    step(); step();
    checks++; if (state !== 4'(ADDIEX) || alusrca !== 1'b1 || alusrcb !== 2'b10 || alucontrol !== 3'b010) begin errors++; $display("FAIL addi_ex: got st=%0d srca=%b srcb=%b aluctl=%b want %0d 1 10 010", state, alusrca, alusrcb, alucontrol, ADDIEX); end
    step();
    checks++; if (state !== 4'(ADDIWB) || regwrite !== 1'b1 || regdst !== 1'b0 || memtoreg !== 1'b0) begin errors++; $display("FAIL addi_wb: got st=%0d rw=%b rd=%b m2r=%b want %0d 1 0 0", state, regwrite, regdst, memtoreg, ADDIWB); end
    step();
    checks++; if (state !== 4'(FETCH)) begin errors++; $display("FAIL addi_cpi: got %0d want %0d", state, FETCH); end
  endtask

  task automatic test_jump();
    opcode = OP_J;
    step(); step();
    checks++; if (state !== 4'(JUMP) || pcsrc !== 2'b10 || pc_en !== 1'b1) begin errors++; $display("FAIL jump: got st=%0d pcsrc=%b pc_en=%b want %0d 10 1", state, pcsrc, pc_en, JUMP); end
    step();
    checks++; if (state !== 4'(FETCH)) begin errors++; $display("FAIL jump_cpi: got %0d want %0d", state, FETCH); end
  endtask

  task automatic test_reset_in_memwr();
    opcode = OP_SW;
    step(); step(); step();
    checks++; if (state !== 4'(MEMWR) || memwrite !== 1'b1 || iord !== 1'b1) begin errors++; $display("FAIL sw_memwr: got st=%0d mw=%b iord=%b want %0d 1 1", state, memwrite, iord, MEMWR); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (state !== 4'(FETCH) || memwrite !== 1'b0) begin errors++; $display("FAIL async_reset: got st=%0d mw=%b want %0d 0", state, memwrite, FETCH); end
    step();
    checks++; if (state !== 4'(FETCH) || memwrite !== 1'b0 || pc_en !== 1'b0 || irwrite !== 1'b0) begin errors++; $display("FAIL held_reset: got st=%0d mw=%b pc_en=%b ir=%b want %0d 0 0 0", state, memwrite, pc_en, irwrite, FETCH); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (pc_en !== 1'b1 || irwrite !== 1'b1) begin errors++; $display("FAIL post_reset_fetch: got pc_en=%b ir=%b want 1 1", pc_en, irwrite); end
    opcode = OP_J;
    step();
    checks++; if (state !== 4'(DECODE)) begin errors++; $display("FAIL post_reset_decode: got %0d want %0d", state, DECODE); end
    step(); step();
  endtask

  task automatic test_unknown();
    opcode = 6'b111111;
    step();
    checks++; if (state !== 4'(DECODE) || regwrite !== 1'b0 || memwrite !== 1'b0) begin errors++; $display("FAIL unk_decode: got st=%0d rw=%b mw=%b want %0d 0 0", state, regwrite, memwrite, DECODE); end
    step();
    checks++; if (state !== 4'(FETCH) || regwrite !== 1'b0 || memwrite !== 1'b0) begin errors++; $display("FAIL unk_nop: got st=%0d rw=%b mw=%b want %0d 0 0", state, regwrite, memwrite, FETCH); end
  endtask

  task automatic test_bne();
    opcode = OP_BNE; zero = 1'b0;
    step();
    checks++; if (state !== 4'(DECODE)) begin errors++; $display("FAIL bne_decode: got %0d want %0d", state, DECODE); end
    step();
`ifdef BNE_SUPPORT_EN
    checks++; if (state !== 4'(BRANCH) || pc_en !== 1'b1) begin errors++; $display("FAIL bne_taken: got st=%0d pc_en=%b want %0d 1", state, pc_en, BRANCH); end
    zero = 1'b1;
    #1;
    checks++; if (pc_en !== 1'b0) begin errors++; $display("FAIL bne_not_taken: got pc_en=%b want 0", pc_en); end
    step();
    zero = 1'b0;
`endif
    checks++; if (state !== 4'(FETCH) || regwrite !== 1'b0 || memwrite !== 1'b0) begin errors++; $display("FAIL bne_end: got st=%0d rw=%b mw=%b want %0d 0 0", state, regwrite, memwrite, FETCH); end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_rtype();
    test_beq();
    test_addi();
    test_jump();
    test_reset_in_memwr();
    test_unknown();
    test_bne();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 Parameters: none; all widths are fixed by the MIPS-I encoding.
REQ-002 clk  in  1  single clock; all state updates occur on the rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 opcode  in  6  instr[31:26] from the instruction register.
REQ-005 funct  in  6  instr[5:0] from the instruction register.
REQ-006 zero  in  1  ALU zero flag.
REQ-007 iord  out  1  select for the address 2:1 mux (0 = PC, 1 = ALUOut).
REQ-008 alusrca  out  1  select for the ALU-A 2:1 mux (0 = PC, 1 = regA).
REQ-009 alusrcb  out  2  ALU-B select (00 = regB, 01 = const 4, 10 = signimm, 11 = signimm<<2).
REQ-010 pcsrc  out  2  next-PC select (00 = ALU result, 01 = ALUOut, 10 = jump target).
REQ-011 irwrite, memwrite, regwrite  out  1 each  write enables.
REQ-012 regdst, memtoreg  out  1 each  2:1 mux selects (regdst 1 = rd; memtoreg 1 = memory data).
REQ-013 pc_en  out  1  PC register enable.
REQ-014 alucontrol  out  3  ALU operation.
REQ-015 state  out  4  current state encoding, for debug and bench observation only.

Function
REQ-016 States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP.
REQ-017 Transitions:
- FETCH->DECODE.
- DECODE: lw/sw->MEMADR; R-type->EXEC; beq->BRANCH; addi->ADDIEX; j->JUMP.
- MEMADR: lw->MEMRD; sw->MEMWR.
- MEMRD->MEMWB.
- EXEC->ALUWB.
- ADDIEX->ADDIWB.
- MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH, JUMP -> FETCH.
REQ-018 An unrecognised opcode in DECODE shall return the FSM to FETCH with no register or memory write, so the instruction executes as a NOP.
REQ-019 Cycles per instruction, counted from entry to FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
REQ-020 Per-state outputs (all unlisted signals are 0):
- FETCH: irwrite=1, pcwrite=1, alusrcb=01, aluop=00.
- DECODE: alusrcb=11, aluop=00.
- MEMADR and ADDIEX: alusrca=1, alusrcb=10, aluop=00.
- MEMRD: iord=1.
- MEMWB: regwrite=1, memtoreg=1.
- MEMWR: iord=1, memwrite=1.
- EXEC: alusrca=1, aluop=10.
- ALUWB: regwrite=1, regdst=1.
- ADDIWB: regwrite=1.
- BRANCH: alusrca=1, aluop=01, pcsrc=01, branch=1.
- JUMP: pcsrc=10, pcwrite=1.
REQ-021 All outputs shall be combinational functions of the registered state, plus opcode/funct/zero where stated; no output has an opcode-to-output path except pc_en and alucontrol.
REQ-022 pc_en = pcwrite | (branch & zero).
REQ-023 alucontrol: aluop 00->010 (add), 01->110 (sub). For aluop 10, decode funct:
- 100000->010, 100010->110, 100100->000, 100101->001, 101010->111.
- Any other funct ->010.
REQ-024 opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
REQ-025 Opcode and funct changes while the FSM is outside DECODE, MEMADR and EXEC shall not affect state transitions.

Reset
REQ-026 Asserting rst_n low shall force the state to FETCH immediately, at any point in an instruction, with no completion of the instruction in flight.
REQ-027 While rst_n is low, pc_en, irwrite, memwrite and regwrite shall be 0; all other outputs shall take their FETCH values.
REQ-028 On the first rising edge after rst_n deasserts, the FSM shall perform a normal FETCH (pc_en=1, irwrite=1).

Configuration
REQ-029 BNE_SUPPORT_EN defined: opcode 000101 (bne) shall decode to BRANCH, and pc_en = pcwrite | (branch & (zero ^ is_bne)), where is_bne = (opcode == 000101).
REQ-030 BNE_SUPPORT_EN undefined: opcode 000101 shall be treated as unrecognised per REQ-018.

Structure
REQ-031 A shared package mips_pkg shall hold:
- the state enum (4-bit);
- opcode and funct localparams;
- the aluop and alucontrol encodings;
- the alusrcb and pcsrc encodings.
REQ-032 One sub-module, alu_decoder (aluop, funct -> alucontrol), shall implement REQ-023 and be instantiated once.

Verification
REQ-033 Release reset, opcode=100011 -> state sequence FETCH,DECODE,MEMADR,MEMRD,MEMWB,FETCH; regwrite=1 and memtoreg=1 only in MEMWB.
REQ-034 R-type with funct=101010 -> alucontrol=111 in EXEC; regwrite=1 and regdst=1 in ALUWB; 4 cycles total.
REQ-035 beq with zero=1 -> pc_en=1 and pcsrc=01 in BRANCH. Same with zero=0 -> pc_en=0; return to FETCH after 3 cycles.
REQ-036 Reset pulse during MEMWR -> state=FETCH asynchronously; memwrite=0 throughout the reset; normal FETCH after release.
REQ-037 opcode=000101 -> with BNE_SUPPORT_EN defined and zero=0, pc_en=1 in BRANCH; without it, sequence is FETCH,DECODE,FETCH with no writes.
REQ-038 opcode=111111 in DECODE -> next state FETCH; regwrite and memwrite stay 0.
